// File: rtl/ifetch_pkg.sv
// Shared constants, queue entry type and PC helper for the instruction fetch unit.
package ifetch_pkg;

    localparam int unsigned PC_W       = 32;
    localparam int unsigned INST_W     = 32;
    localparam int unsigned ENTRY_W    = PC_W + INST_W;
    localparam int unsigned RST_PC_DEF = 0;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } q_entry_t;

    // Word-indexed increment that wraps from the last memory word back to 0.
    function automatic logic [PC_W-1:0] pc_incr(input logic [PC_W-1:0] pc,
                                                 input int unsigned im_size);
        logic [PC_W-1:0] nxt;
        if (pc == PC_W'(im_size - 1)) begin
            nxt = {PC_W{1'b0}};
        end else begin
            nxt = pc + {{(PC_W-1){1'b0}}, 1'b1};
        end
        return nxt;
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-side bundle: INST_MEM port, redirect, decode handshake and status.
// Counter outputs exist only when IFETCH_STAT_EN is defined.
interface inst_fetch_if
    import ifetch_pkg::*;
#(
    parameter int unsigned QDEPTH = 4
);
    localparam int unsigned CW = $clog2(QDEPTH) + 1;

    logic [PC_W-1:0]   im_pc;
    logic [INST_W-1:0] im_inst;
    logic              redirect;
    logic [PC_W-1:0]   redirect_pc;
    logic              dec_valid;
    logic              dec_ready;
    logic [INST_W-1:0] dec_inst;
    logic [PC_W-1:0]   dec_pc;
    logic [CW-1:0]     q_count;
    logic              pc_err;
`ifdef IFETCH_STAT_EN
    logic [31:0]       fetch_cnt;
    logic [31:0]       flush_cnt;
`endif

    modport master (
        output im_pc,
        input  im_inst,
        input  redirect,
        input  redirect_pc,
        output dec_valid,
        input  dec_ready,
        output dec_inst,
        output dec_pc,
        output q_count,
`ifdef IFETCH_STAT_EN
        output fetch_cnt,
        output flush_cnt,
`endif
        output pc_err
    );

    modport slave (
        input  im_pc,
        output im_inst,
        output redirect,
        output redirect_pc,
        input  dec_valid,
        output dec_ready,
        input  dec_inst,
        input  dec_pc,
        input  q_count,
`ifdef IFETCH_STAT_EN
        input  fetch_cnt,
        input  flush_cnt,
`endif
        input  pc_err
    );

endinterface

// File: rtl/inst_queue.sv
// Synchronous FIFO of fetched {pc, inst} entries; flush beats push and pop.
// Storage is reset so the head never reads X.
module inst_queue #(
    parameter int unsigned QDEPTH = 4,
    parameter int unsigned W      = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic [W-1:0]               din_i,
    output logic [W-1:0]               head_o,
    output logic [$clog2(QDEPTH):0]    count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int unsigned AW = $clog2(QDEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem_q [QDEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push_s;
    logic          do_pop_s;

    assign full_o  = (count_q == CW'(QDEPTH));
    assign empty_o = (count_q == {CW{1'b0}});
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Pointer and occupancy next-state; full/empty gate pushes and pops.
    always_comb begin
        do_push_s = push_i & ~full_o & ~flush_i;
        do_pop_s  = pop_i & ~empty_o & ~flush_i;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (flush_i) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
                2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage, cleared on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(QDEPTH); i++) begin
                mem_q[i] <= {W{1'b0}};
            end
        end else if (do_push_s) begin
            mem_q[wr_ptr_q] <= din_i;
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: word-indexed PC, fetch queue toward decode, redirect/flush.
// Define IFETCH_STAT_EN to add saturating fetch/flush counters.
module inst_fetch
    import ifetch_pkg::*;
#(
    parameter int unsigned IM_SIZE = 100,
    parameter int unsigned QDEPTH  = 4,
    parameter int unsigned RST_PC  = RST_PC_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    inst_fetch_if.master  bus
);
    localparam int unsigned CW = $clog2(QDEPTH) + 1;

    logic [PC_W-1:0] pc_q, pc_d;
    logic            pc_err_q, pc_err_d;
    logic            push_s;
    logic            pop_s;
    logic            full_s;
    logic            empty_s;
    logic            tgt_ok_s;
    logic [CW-1:0]   count_s;
    q_entry_t        push_entry_s;
    q_entry_t        head_s;

    assign push_entry_s = '{pc: pc_q, inst: bus.im_inst};

    // Push decision uses only pre-edge occupancy; a same-cycle pop does not free a slot.
    always_comb begin
        tgt_ok_s = (bus.redirect_pc < PC_W'(IM_SIZE));
        push_s   = ~bus.redirect & ~full_s;
        pop_s    = ~empty_s & bus.dec_ready;
        pc_err_d = pc_err_q;
        pc_d     = pc_q;
        if (bus.redirect) begin
            if (tgt_ok_s) begin
                pc_d = bus.redirect_pc;
            end else begin
                pc_d     = {PC_W{1'b0}};
                pc_err_d = 1'b1;
            end
        end else if (push_s) begin
            pc_d = pc_incr(pc_q, IM_SIZE);
        end else begin
            pc_d = pc_q;
        end
    end

    // PC and sticky range-error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= PC_W'(RST_PC);
            pc_err_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            pc_err_q <= pc_err_d;
        end
    end

    inst_queue #(
        .QDEPTH (QDEPTH),
        .W      (ENTRY_W)
    ) u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .flush_i (bus.redirect),
        .din_i   (push_entry_s),
        .head_o  (head_s),
        .count_o (count_s),
        .full_o  (full_s),
        .empty_o (empty_s)
    );

    assign bus.im_pc     = pc_q;
    assign bus.dec_valid = ~empty_s;
    assign bus.dec_inst  = head_s.inst;
    assign bus.dec_pc    = head_s.pc;
    assign bus.q_count   = count_s;
    assign bus.pc_err    = pc_err_q;

`ifdef IFETCH_STAT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Saturating event counters.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (push_s && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end else begin
            fetch_cnt_d = fetch_cnt_q;
        end
        if (bus.redirect && (flush_cnt_q != 32'hFFFF_FFFF)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.fetch_cnt = fetch_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
`endif

endmodule
